// File: rtl/atta_led_pkg.sv
// Shared definitions for the atta LED controller: channel modes, register
// field positions and the trap-control address decode.
package atta_led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_DIRECT = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_PWM    = 2'd3
  } mode_e;

  localparam int ADDR_W       = 5;
  localparam int MODE_LSB     = 0;
  localparam int MODE_W       = 2;
  localparam int DUTY_LSB     = 2;
  localparam int TRAP_CLR_BIT = 0;

  // The trap-control register sits directly after the last channel register.
  function automatic logic is_trap_addr(input logic [ADDR_W-1:0] addr, input int n_ch);
    return addr == ADDR_W'(n_ch);
  endfunction

endpackage

// File: rtl/atta_led_ch.sv
// One LED channel: mode/duty registers, duty shadow reloaded on PWM wrap,
// output mux and output flop.
module atta_led_ch
  import atta_led_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [PWM_BITS+1:0]   wr_field,
  input  logic                  gpio,
  input  logic                  blink,
  input  logic [PWM_BITS-1:0]   pwm_cnt,
  input  logic                  pwm_wrap,
  output logic                  led
);

  mode_e               mode_q;
  mode_e               mode_next;
  logic [PWM_BITS-1:0] duty_q;
  logic [PWM_BITS-1:0] duty_next;
  logic [PWM_BITS-1:0] duty_active;
  logic                led_next;

  // Forward the write so a new mode shows on the very next output edge.
  assign mode_next = wr_en ? mode_e'(wr_field[MODE_LSB +: MODE_W]) : mode_q;
  assign duty_next = wr_en ? wr_field[DUTY_LSB +: PWM_BITS] : duty_q;

  always_comb begin
    led_next = 1'b0;
    case (mode_next)
      MODE_OFF:    led_next = 1'b0;
      MODE_DIRECT: led_next = gpio;
      MODE_BLINK:  led_next = blink;
      MODE_PWM:    led_next = (pwm_cnt < duty_active);
      default:     led_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_DIRECT;
      duty_q      <= '0;
      duty_active <= '0;
      led         <= 1'b0;
    end else begin
      mode_q <= mode_next;
      duty_q <= duty_next;
      if (pwm_wrap) duty_active <= duty_next;
      led <= led_next;
    end
  end

endmodule

// File: rtl/atta_led_ctrl.sv
// LED/indicator controller: shared prescaler, PWM and blink timebases, sticky
// trap indicator, and N_CH independently configured LED channels.
module atta_led_ctrl
  import atta_led_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int PWM_BITS  = 8,
  parameter int PRESCALE  = 390,
  parameter int BLINK_DIV = 25_000_000,
  parameter int TRAP_DIV  = 6_250_000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N_CH-1:0]   gpio_i,
  input  logic              trap_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [31:0]       wr_data_i,
  output logic [N_CH-1:0]   led_o,
  output logic              trap_led_o
);

  localparam int PS_W = (PRESCALE  > 1) ? $clog2(PRESCALE)  : 1;
  localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int TR_W = (TRAP_DIV  > 1) ? $clog2(TRAP_DIV)  : 1;

  logic [PS_W-1:0]     presc_cnt;
  logic                step;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_wrap;
  logic [BL_W-1:0]     blink_cnt;
  logic                blink_wrap;
  logic                blink_phase;
  logic [TR_W-1:0]     trap_cnt;
  logic                trap_wrap;
  logic                trap_latch;
  logic                trap_latch_next;
  logic                trap_clr;
  logic                unused_data;

  assign step       = (presc_cnt == PS_W'(PRESCALE - 1));
  assign pwm_wrap   = step && (pwm_cnt == '1);
  assign blink_wrap = (blink_cnt == BL_W'(BLINK_DIV - 1));
  assign trap_wrap  = (trap_cnt == TR_W'(TRAP_DIV - 1));

  assign unused_data = ^wr_data_i[31:PWM_BITS+2];

  // A trap arriving in the same cycle as the clear keeps the latch set.
  assign trap_clr        = wr_en_i && is_trap_addr(wr_addr_i, N_CH) && wr_data_i[TRAP_CLR_BIT];
  assign trap_latch_next = trap_i || (trap_latch && !trap_clr);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_cnt   <= '0;
      pwm_cnt     <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      presc_cnt <= step ? '0 : presc_cnt + 1'b1;
      if (step) pwm_cnt <= pwm_cnt + 1'b1;
      if (blink_wrap) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Trap counter only runs once the latch is already set, so the first
  // toggle lands TRAP_DIV cycles after the latch goes high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trap_latch <= 1'b0;
      trap_cnt   <= '0;
      trap_led_o <= 1'b0;
    end else begin
      trap_latch <= trap_latch_next;
      if (!trap_latch_next) begin
        trap_cnt   <= '0;
        trap_led_o <= 1'b0;
      end else if (trap_latch) begin
        if (trap_wrap) begin
          trap_cnt   <= '0;
          trap_led_o <= ~trap_led_o;
        end else begin
          trap_cnt <= trap_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    atta_led_ch #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk      (clk_i),
      .rst      (rst_i),
      .wr_en    (wr_en_i && (wr_addr_i == ADDR_W'(i))),
      .wr_field (wr_data_i[PWM_BITS+1:0]),
      .gpio     (gpio_i[i]),
      .blink    (blink_phase),
      .pwm_cnt  (pwm_cnt),
      .pwm_wrap (pwm_wrap),
      .led      (led_o[i])
    );
  end

endmodule

// File: doc/atta_led_ctrl.md
# atta_led_ctrl

Parametrised LED/indicator controller between the atta system's GPIO word and the board LEDs. It generalises the fixed "GPIO bit to LED, trap to LED" wiring to N_CH channels. Each channel has a run-time mode: off, direct, blink or PWM dim. A sticky trap indicator blinks until software clears it. Sits in the top level, clocked from the system clock, configured through a simple synchronous write port from the system bus.

## Interface
- N_CH, 4: number of LED channels (1..16)
- PWM_BITS, 8: PWM counter/duty width
- PRESCALE, 390: clk cycles per PWM count step (>=1)
- BLINK_DIV, 25_000_000: clk cycles per blink half-period (>=1)
- TRAP_DIV, 6_250_000: clk cycles per trap-blink half-period (>=1)

- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- gpio_i  in  N_CH  GPIO bits from the system, used in DIRECT mode
- trap_i  in  1  CPU trap level
- wr_en_i  in  1  register write strobe, single cycle
- wr_addr_i  in  5  register index
- wr_data_i  in  32  write data
- led_o  out  N_CH  channel LED outputs, registered
- trap_led_o  out  1  trap indicator, registered

## Operation
- Register map:
  - addr 0..N_CH-1: channel control; [1:0] mode, [PWM_BITS+1:2] duty.
  - addr N_CH: trap control; bit0 write-1-to-clear.
  - Other addresses are ignored.
- Modes:
  - 0 OFF: led=0.
  - 1 DIRECT: led=gpio_i[ch].
  - 2 BLINK: led=shared blink phase.
  - 3 PWM: led=(pwm_cnt < duty_active).
- Reset:
  - All channels go to mode DIRECT, duty 0.
  - All counters go to 0; blink phase 0; trap latch 0.
  - led_o=0, trap_led_o=0.
- Prescaler: counts 0..PRESCALE-1 and emits a one-cycle step on wrap.
- PWM counter: advances on each step, wrapping from 2^PWM_BITS-1 to 0. It is shared by all channels.
- Duty shadowing:
  - duty_active loads from the written duty only when the PWM counter wraps to 0.
  - This gives a glitch-free duty change.
  - Mode changes apply immediately.
- Duty endpoints: duty 0 is constantly off. Max duty is on for (2^PWM_BITS-1) of 2^PWM_BITS slots.
- Blink counter:
  - Counts 0..BLINK_DIV-1; the phase toggles on wrap.
  - The phase is shared, so all BLINK channels are in lockstep.
  - Entering BLINK does not reset the phase.
- Trap latch:
  - Sets when trap_i=1 and clears on a W1C write.
  - If set and clear occur in the same cycle, set wins.
  - While latched, trap_led_o toggles every TRAP_DIV cycles.
  - When unlatched, trap_led_o=0 and the trap counter is held at 0.
  - Latching starts the first toggle TRAP_DIV cycles later; trap_led_o stays 0 until then.
- Writes with wr_data_i bits above the defined fields are ignored.

## Timing
- All outputs are registered.
- DIRECT: led_o reflects gpio_i one cycle later.
- Write at cycle t: new mode is visible on led_o at t+1. New duty becomes visible at the first PWM wrap at or after t+1.
- trap_i high at cycle t: latch=1 at t+1, first trap_led_o high at t+1+TRAP_DIV.
- Reset asserted mid-operation: all state returns to reset values on the next edge, regardless of pending writes. A write coincident with reset is dropped.
- Counters never exceed their limits.
- PRESCALE=1 steps the PWM counter every cycle.
- BLINK_DIV=1 toggles the phase every cycle.

## Structure
- Package atta_led_pkg holds:
  - mode constants MODE_OFF/DIRECT/BLINK/PWM;
  - register field offsets;
  - the trap-control address rule (addr==N_CH).
- Shared prescaler, PWM counter, blink counter and trap logic live in atta_led_ctrl.
- Sub-module atta_led_ch, instantiated N_CH times via generate, contains:
  - mode/duty registers;
  - the duty shadow;
  - the output mux and output flop.

## Test plan
Bench parameters: N_CH=4, PWM_BITS=4, PRESCALE=1, BLINK_DIV=8, TRAP_DIV=4.
- Reset then gpio_i=4'b1010 with no writes -> led_o=4'b1010 one cycle later; trap_led_o=0.
- Write ch0 mode=BLINK -> led_o[0] toggles every 8 cycles in lockstep with a second BLINK channel enabled later.
- Write ch1 mode=PWM duty=4 -> led_o[1] high exactly 4 of every 16 cycles. Write duty=12 mid-period -> the old duty holds until wrap, then 12/16. Duty 0 -> led_o[1] stays 0.
- Pulse trap_i one cycle -> trap_led_o toggles every 4 cycles indefinitely. W1C write to addr 4 -> trap_led_o=0 next cycle. trap_i=1 coincident with clear -> latch stays set.
- Write to addr 7 and addr 31 -> no output or register change.
- Assert rst_i during PWM/blink activity -> next cycle led_o=0, trap_led_o=0, all channels back in DIRECT mode.
